// File: rtl/layer_sched_pkg.sv
// Shared types for the layer job scheduler: FSM states, the latched job record and grant-id width.
package layer_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        ACCEPT,
        RUN,
        RESP
    } sched_state_e;

    localparam int LAYER_ADDR_W = 10;
    localparam int NUM_REQ_DEF  = 4;
    localparam int ID_W         = (NUM_REQ_DEF > 1) ? $clog2(NUM_REQ_DEF) : 1;

    typedef struct packed {
        logic [LAYER_ADDR_W-1:0] token_base;
        logic [LAYER_ADDR_W-1:0] weight_base;
        logic [LAYER_ADDR_W-1:0] result_base;
    } layer_job_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter
    import layer_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IW      = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx,
    output logic               any
);

    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/layer_job_scheduler.sv
// Round-robin sharing of one layer engine among NUM_REQ requesters, one job in flight.
// Optional LAYER_SCHED_PERF_EN adds cycle and completed-job counters.
module layer_job_scheduler
    import layer_sched_pkg::*;
#(
    parameter  int NUM_REQ       = 4,
    parameter  int ADDR_WIDTH    = LAYER_ADDR_W,
    parameter  int START_TIMEOUT = 8,
    localparam int ID_W          = id_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_token_base,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_weight_base,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_result_base,
    output logic [NUM_REQ-1:0]            rsp_done,
    output logic [NUM_REQ-1:0]            rsp_err,
    output logic                          eng_start,
    input  logic                          eng_busy,
    output logic [ADDR_WIDTH-1:0]         eng_token_base,
    output logic [ADDR_WIDTH-1:0]         eng_weight_base,
    output logic [ADDR_WIDTH-1:0]         eng_result_base,
    output logic [ID_W-1:0]               grant_id,
    output logic                          sched_busy,
    output logic [31:0]                   perf_cycles,
    output logic [15:0]                   perf_jobs
);

    localparam int TW = $clog2(START_TIMEOUT);

    sched_state_e       state;
    logic [ID_W-1:0]    ptr;
    logic [TW-1:0]      timer;
    layer_job_t         job_q;
    logic [NUM_REQ-1:0] arb_grant;
    logic [ID_W-1:0]    arb_idx;
    logic               arb_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    assign req_ready       = (state == IDLE) ? arb_grant : '0;
    assign sched_busy      = (state != IDLE);
    assign eng_token_base  = ADDR_WIDTH'(job_q.token_base);
    assign eng_weight_base = ADDR_WIDTH'(job_q.weight_base);
    assign eng_result_base = ADDR_WIDTH'(job_q.result_base);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            timer     <= '0;
            grant_id  <= '0;
            job_q     <= '0;
            eng_start <= 1'b0;
            rsp_done  <= '0;
            rsp_err   <= '0;
        end else begin
            eng_start <= 1'b0;
            rsp_done  <= '0;
            rsp_err   <= '0;
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        job_q.token_base  <= LAYER_ADDR_W'(req_token_base[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH]);
                        job_q.weight_base <= LAYER_ADDR_W'(req_weight_base[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH]);
                        job_q.result_base <= LAYER_ADDR_W'(req_result_base[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH]);
                        grant_id  <= arb_idx;
                        ptr       <= (arb_idx == ID_W'(NUM_REQ-1)) ? '0 : arb_idx + 1'b1;
                        eng_start <= 1'b1;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    timer <= '0;
                    state <= ACCEPT;
                end
                // busy already high before ACCEPT is ignored; only this sampling counts
                ACCEPT: begin
                    if (eng_busy) begin
                        state <= RUN;
                    end else if (timer == TW'(START_TIMEOUT-1)) begin
                        rsp_err[grant_id] <= 1'b1;
                        state             <= RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RUN: begin
                    if (!eng_busy) begin
                        rsp_done[grant_id] <= 1'b1;
                        state              <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LAYER_SCHED_PERF_EN
    logic [31:0] perf_cnt;
    logic [31:0] perf_cycles_q;
    logic [15:0] perf_jobs_q;

    // perf_cnt equals cycles elapsed since the LAUNCH cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cnt      <= '0;
            perf_cycles_q <= '0;
            perf_jobs_q   <= '0;
        end else begin
            if (state == LAUNCH) begin
                perf_cnt <= 32'd1;
            end else if (state == ACCEPT || state == RUN) begin
                perf_cnt <= perf_cnt + 32'd1;
            end
            if (state == RESP && (|rsp_done)) begin
                perf_cycles_q <= perf_cnt;
                perf_jobs_q   <= perf_jobs_q + 16'd1;
            end
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_jobs   = perf_jobs_q;
`else
    assign perf_cycles = '0;
    assign perf_jobs   = '0;
`endif

endmodule
